// File: rtl/fdiv_pipe_pkg.sv
// Shared FPU definitions: IEEE-754 single field layout, special-case classes and constants.
package fdiv_pipe_pkg;

   localparam int unsigned SIGN_BIT = 31;
   localparam int unsigned EXP_MSB  = 30;
   localparam int unsigned EXP_LSB  = 23;
   localparam int unsigned MANT_MSB = 22;

   localparam int unsigned EXP_BIAS = 127;
   localparam int unsigned EXP_MAX  = 255;

   typedef enum logic [1:0] {
      ClsNormal = 2'd0,
      ClsZero   = 2'd1,
      ClsInf    = 2'd2
   } fclass_e;

   localparam logic [31:0] FP_POS_INF  = 32'h7F80_0000;
   localparam logic [31:0] FP_NEG_INF  = 32'hFF80_0000;
   localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

   // Divide special cases, judged from a and finv(b). finv maps b=0 to inf and b=inf to zero,
   // so y's exponent stands in for b's.
   function automatic fclass_e classify(input logic [31:0] a, input logic [31:0] y);
      fclass_e cls;
      if (a[EXP_MSB:EXP_LSB] == '0) begin
         cls = ClsZero;
      end else if (y[EXP_MSB:EXP_LSB] == '1) begin
         cls = ClsInf;
      end else if (a[EXP_MSB:EXP_LSB] == '1) begin
         cls = ClsInf;
      end else if (y[EXP_MSB:EXP_LSB] == '0) begin
         cls = ClsZero;
      end else begin
         cls = ClsNormal;
      end
      return cls;
   endfunction

endpackage

// File: rtl/fdiv_pipe_fmul_core.sv
// Two-stage single-precision multiplier back end (multiply, then normalise/round) with a
// special-case class override. Also usable as the standalone FPU multiplier.
module fmul_core
   import fdiv_pipe_pkg::*;
#(
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [TAG_W-1:0] in_tag,
   input  fclass_e          in_cls,
   output logic             m1_valid,
   output logic [TAG_W-1:0] m1_tag,
   output logic             out_valid,
   output logic [31:0]      out_data,
   output logic [TAG_W-1:0] out_tag
);

   logic              m1_sign_q;
   logic [7:0]        m1_ea_q;
   logic [7:0]        m1_eb_q;
   fclass_e           m1_cls_q;
   logic [25:0]       m1_prod_q;  // product bits [47:22]; lower bits never reach the result

   logic [47:0]       ma_w;
   logic [47:0]       mb_w;
   logic [25:0]       prod_top;
   logic [23:0]       mant_r;
   logic signed [9:0] exp_r;
   logic [31:0]       res;

   // M1 operands: 24x24 significand product, keeping only what normalise/round needs.
   always_comb begin
      ma_w     = {24'd0, 1'b1, in_a[MANT_MSB:0]};
      mb_w     = {24'd0, 1'b1, in_b[MANT_MSB:0]};
      prod_top = 26'((ma_w * mb_w) >> 22);
   end

   // M2: normalise by product[47], round half-up on the guard bit, then range-check.
   always_comb begin
      mant_r = '0;
      exp_r  = '0;
      res    = '0;
      if (m1_prod_q[25]) begin
         mant_r = {1'b0, m1_prod_q[24:2]} + 24'(m1_prod_q[1]);
         exp_r  = $signed({2'b00, m1_ea_q}) + $signed({2'b00, m1_eb_q})
                  - $signed(10'(EXP_BIAS - 1));
      end else begin
         mant_r = {1'b0, m1_prod_q[23:1]} + 24'(m1_prod_q[0]);
         exp_r  = $signed({2'b00, m1_ea_q}) + $signed({2'b00, m1_eb_q})
                  - $signed(10'(EXP_BIAS));
      end
      if (mant_r[23]) begin
         mant_r = '0;
         exp_r  = exp_r + 10'sd1;
      end
      unique case (m1_cls_q)
         ClsZero: res = {m1_sign_q, FP_POS_ZERO[30:0]};
         ClsInf:  res = m1_sign_q ? FP_NEG_INF : FP_POS_INF;
         default: begin
            if (exp_r >= $signed(10'(EXP_MAX))) begin
               res = m1_sign_q ? FP_NEG_INF : FP_POS_INF;
            end else if (exp_r <= 10'sd0) begin
               res = {m1_sign_q, FP_POS_ZERO[30:0]};
            end else begin
               res = {m1_sign_q, exp_r[7:0], mant_r[22:0]};
            end
         end
      endcase
   end

   // Stage registers for M1 and the registered outputs of M2.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         m1_valid  <= 1'b0;
         m1_tag    <= '0;
         m1_sign_q <= 1'b0;
         m1_ea_q   <= '0;
         m1_eb_q   <= '0;
         m1_cls_q  <= ClsNormal;
         m1_prod_q <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_tag   <= '0;
      end else begin
         m1_valid  <= in_valid;
         m1_tag    <= in_tag;
         m1_sign_q <= in_a[SIGN_BIT] ^ in_b[SIGN_BIT];
         m1_ea_q   <= in_a[EXP_MSB:EXP_LSB];
         m1_eb_q   <= in_b[EXP_MSB:EXP_LSB];
         m1_cls_q  <= in_cls;
         m1_prod_q <= prod_top;
         out_valid <= m1_valid;
         out_data  <= res;
         out_tag   <= m1_tag;
      end
   end

endmodule

// File: rtl/finv.sv
// Single-precision reciprocal, 3 cycles from x to y. Denormals flush to zero, no NaN handling.
module finv
   import fdiv_pipe_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] x,
   output logic [31:0] y
);

   localparam logic [48:0] RECIP_NUM = 49'h1_0000_0000_0000; // 2^48

   logic [31:0]       x_q;
   logic              sign_q;
   logic              inf_q;
   logic              zero_q;
   logic [7:0]        exp_q;
   logic [22:0]       mant_q;

   logic [7:0]        ex;
   logic [22:0]       mx;
   logic signed [9:0] e_full;
   logic              inf_d;
   logic              zero_d;
   logic [22:0]       mant_d;

   // Reciprocal of the significand: 2^48 / {1,mx} lies in (2^24, 2^25), bits [23:1] are the mantissa.
   always_comb begin
      ex     = x_q[EXP_MSB:EXP_LSB];
      mx     = x_q[MANT_MSB:0];
      // An exact power of two keeps a zero mantissa; otherwise 1/m < 1 costs one exponent step.
      e_full = ((mx == '0) ? $signed(10'(2 * EXP_BIAS)) : $signed(10'(2 * EXP_BIAS - 1)))
               - $signed({2'b00, ex});
      inf_d  = (ex == '0);
      zero_d = (ex == '1) || (e_full <= 10'sd0);
      mant_d = (mx == '0) ? '0 : 23'((RECIP_NUM / {25'd0, 1'b1, mx}) >> 1);
   end

   // Three register stages: capture, reciprocal, pack.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         x_q    <= '0;
         sign_q <= 1'b0;
         inf_q  <= 1'b0;
         zero_q <= 1'b0;
         exp_q  <= '0;
         mant_q <= '0;
         y      <= '0;
      end else begin
         x_q    <= x;
         sign_q <= x_q[SIGN_BIT];
         inf_q  <= inf_d;
         zero_q <= zero_d;
         exp_q  <= e_full[7:0];
         mant_q <= mant_d;
         if (inf_q) begin
            y <= {sign_q, 8'hFF, 23'd0};
         end else if (zero_q) begin
            y <= {sign_q, 31'd0};
         end else begin
            y <= {sign_q, exp_q, mant_q};
         end
      end
   end

endmodule

// File: rtl/fdiv_pipe.sv
// Pipelined single-precision divider: q = a * finv(b). a, tag and valid ride a delay line
// matched to finv, then fmul_core multiplies and rounds. Fixed latency, no backpressure.
module fdiv_pipe
   import fdiv_pipe_pkg::*;
#(
   parameter int unsigned FINV_LAT = 3,  // must match the finv instance
   parameter int unsigned TAG_W    = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [TAG_W-1:0] in_tag,
   input  logic [TAG_W-1:0] q_tag,
   output logic             q_hit,
   output logic             busy,
   output logic             out_valid,
   output logic [31:0]      out_data,
   output logic [TAG_W-1:0] out_tag
);

   localparam int unsigned LAT = FINV_LAT + 2;

   logic [FINV_LAT-1:0] dl_valid_q;
   logic [TAG_W-1:0]    dl_tag_q [FINV_LAT];
   logic [31:0]         dl_a_q   [FINV_LAT];

   logic [31:0]         y;
   fclass_e             cls;
   logic                m1_valid;
   logic [TAG_W-1:0]    m1_tag;

   logic [LAT-1:0]      stg_valid;
   logic [TAG_W-1:0]    stg_tag [LAT];

   // Delay line keeping a, tag and valid aligned with finv's output.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         dl_valid_q <= '0;
         for (int i = 0; i < FINV_LAT; i++) begin
            dl_tag_q[i] <= '0;
            dl_a_q[i]   <= '0;
         end
      end else begin
         dl_valid_q[0] <= in_valid;
         dl_tag_q[0]   <= in_tag;
         dl_a_q[0]     <= in_a;
         for (int i = 1; i < FINV_LAT; i++) begin
            dl_valid_q[i] <= dl_valid_q[i-1];
            dl_tag_q[i]   <= dl_tag_q[i-1];
            dl_a_q[i]     <= dl_a_q[i-1];
         end
      end
   end

   finv u_finv (
      .clk  (clk),
      .rstn (rstn),
      .x    (in_b),
      .y    (y)
   );

   assign cls = classify(dl_a_q[FINV_LAT-1], y);

   fmul_core #(
      .TAG_W (TAG_W)
   ) u_fmul (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (dl_valid_q[FINV_LAT-1]),
      .in_a      (dl_a_q[FINV_LAT-1]),
      .in_b      (y),
      .in_tag    (dl_tag_q[FINV_LAT-1]),
      .in_cls    (cls),
      .m1_valid  (m1_valid),
      .m1_tag    (m1_tag),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   // Gather valid/tag of every registered stage 1..LAT, output stage included.
   always_comb begin
      stg_valid = '0;
      for (int i = 0; i < LAT; i++) begin
         stg_tag[i] = '0;
      end
      for (int i = 0; i < FINV_LAT; i++) begin
         stg_valid[i] = dl_valid_q[i];
         stg_tag[i]   = dl_tag_q[i];
      end
      stg_valid[FINV_LAT] = m1_valid;
      stg_tag[FINV_LAT]   = m1_tag;
      stg_valid[LAT-1]    = out_valid;
      stg_tag[LAT-1]      = out_tag;
   end

   // In-flight status for the issue stage; the op being issued this cycle is not counted.
   always_comb begin
      busy  = 1'b0;
      q_hit = 1'b0;
      for (int i = 0; i < LAT; i++) begin
         busy  = busy | stg_valid[i];
         q_hit = q_hit | (stg_valid[i] && (stg_tag[i] == q_tag));
      end
   end

endmodule

// File: tb/tb_fdiv_pipe.sv
// Scoreboard bench for fdiv_pipe: stimulus pushes expected results, a monitor pops and compares.
module tb_fdiv_pipe;

   localparam int unsigned LAT = 5;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [4:0]  in_tag;
   logic [4:0]  q_tag;
   logic        q_hit;
   logic        busy;
   logic        out_valid;
   logic [31:0] out_data;
   logic [4:0]  out_tag;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  tag;
      int          tol;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   pulses = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   fdiv_pipe #(
      .FINV_LAT (3),
      .TAG_W    (5)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .q_tag     (q_tag),
      .q_hit     (q_hit),
      .busy      (busy),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, req);
   endtask

   // Called right after a posedge; the op is captured at the next edge.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] res, input int tol);
      exp_t e;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_tag   = tag;
      e.data   = res;
      e.tag    = tag;
      e.tol    = tol;
      e.cyc    = cyc + LAT;
      sb.push_back(e);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Monitor: every out_valid pulse must match the oldest expected result.
   always @(negedge clk) begin
      exp_t e;
      int   d;
      if (out_valid === 1'b1) begin
         pulses++;
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_out: got data=%h tag=%0d, expected no output",
                     out_data, out_tag);
         end else begin
            e = sb.pop_front();
            check("out_tag", 32'(out_tag), 32'(e.tag));
            check("latency_cycle", cyc, e.cyc);
            if (e.tol == 0) begin
               check("out_data", out_data, e.data);
            end else begin
               n_checks++;
               d = (out_data > e.data) ? int'(out_data - e.data) : int'(e.data - out_data);
               if (!$isunknown(out_data) && d <= e.tol) n_pass++;
               else $display("FAIL out_data_ulp: got %h, expected %h +/- %0d ulp",
                             out_data, e.data, e.tol);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1);
   end

   initial begin
      int          p0;
      logic [4:0]  qts [2];
      qts[0] = 5'd7;
      qts[1] = 5'd8;

      // Reset with a live op on the inputs: nothing may survive.
      rstn     = 1'b0;
      in_valid = 1'b1;
      in_a     = 32'h40C0_0000;
      in_b     = 32'h4000_0000;
      in_tag   = 5'd5;
      q_tag    = 5'd5;
      repeat (3) @(posedge clk);
      #1;
      rstn     = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_tag", 32'(out_tag), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_q_hit", 32'(q_hit), 32'd0);

      // 6 / 2, single pulse.
      p0 = pulses;
      issue(32'h40C0_0000, 32'h4000_0000, 5'd3, 32'h4040_0000, 0);
      idle();
      repeat (8) @(negedge clk);
      check("single_pulse", pulses - p0, 32'd1);

      // Signs and divide-by-zero / zero-dividend classes.
      issue(32'hBF80_0000, 32'h4080_0000, 5'd1, 32'hBE80_0000, 0);
      idle();
      issue(32'h3F80_0000, 32'h0000_0000, 5'd2, 32'h7F80_0000, 0);
      idle();
      issue(32'h0000_0000, 32'h4040_0000, 5'd4, 32'h0000_0000, 0);
      idle();

      // Exponent overflow and underflow.
      issue(32'h7F00_0000, 32'h3E80_0000, 5'd6, 32'h7F80_0000, 0);
      idle();
      issue(32'h0080_0000, 32'h4080_0000, 5'd6, 32'h0000_0000, 0);
      idle();
      repeat (8) @(negedge clk);

      // Back-to-back issue: 10/2, 1.5/0.125, -123/8, 1/3.
      p0 = pulses;
      issue(32'h4120_0000, 32'h4000_0000, 5'd1, 32'h40A0_0000, 0);
      issue(32'h3FC0_0000, 32'h3E00_0000, 5'd2, 32'h4140_0000, 0);
      issue(32'hC2F6_0000, 32'h4100_0000, 5'd3, 32'hC176_0000, 0);
      issue(32'h3F80_0000, 32'h4040_0000, 5'd4, 32'h3EAA_AAAB, 1);
      idle();
      repeat (8) @(negedge clk);
      check("burst_pulses", pulses - p0, 32'd4);

      // Hazard query: 4 / 0.5 with tag 7, queried with a matching and a non-matching tag.
      for (int t = 0; t < 2; t++) begin
         exp_t e;
         @(posedge clk);
         #1;
         q_tag    = qts[t];
         in_valid = 1'b1;
         in_a     = 32'h4080_0000;
         in_b     = 32'h3F00_0000;
         in_tag   = 5'd7;
         e.data   = 32'h4100_0000;
         e.tag    = 5'd7;
         e.tol    = 0;
         e.cyc    = cyc + LAT;
         sb.push_back(e);
         @(negedge clk);
         check("hz_q_hit_c0", 32'(q_hit), 32'd0);
         check("hz_busy_c0", 32'(busy), 32'd0);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            else @(negedge clk);
            check($sformatf("hz_q_hit_q%0d_c%0d", qts[t], k), 32'(q_hit),
                  32'((qts[t] == 5'd7) && (k <= 5)));
            check($sformatf("hz_busy_c%0d", k), 32'(busy), 32'(k <= 5));
         end
      end

      // Reset mid-flight: two ops issued, a third offered in the reset cycle.
      issue(32'h4000_0000, 32'h3F80_0000, 5'd10, 32'h4000_0000, 0);
      issue(32'h4040_0000, 32'h3F80_0000, 5'd11, 32'h4040_0000, 0);
      @(posedge clk);
      #1;
      rstn     = 1'b0;
      in_tag   = 5'd12;
      q_tag    = 5'd10;
      @(posedge clk);
      #1;
      rstn     = 1'b1;
      in_valid = 1'b0;
      sb.delete();
      p0 = pulses;
      @(negedge clk);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_q_hit", 32'(q_hit), 32'd0);
      repeat (10) @(negedge clk);
      check("midrst_no_out", pulses - p0, 32'd0);

      // Fresh op after the reset completes normally.
      issue(32'h40C0_0000, 32'h4000_0000, 5'd9, 32'h4040_0000, 0);
      idle();
      repeat (10) @(negedge clk);
      check("sb_drained", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fdiv_pipe.md
Name: fdiv_pipe

Overview:
- Fully pipelined single-precision divider for the FPU: q = a / b = a × finv(b).
- Feeds b into the existing `finv` block (3-cycle latency from input to `y`).
- Delays a, the destination-register tag and a valid bit alongside finv.
- A two-stage multiply/normalise/round back end then consumes finv's `y`.
- Fixed latency, no backpressure. A per-tag in-flight query lets the issue stage detect RAW hazards.

Parameters:
- FINV_LAT, 3: cycles from finv input `x` to valid `y`; sets the a/tag/valid delay-line depth.
- TAG_W, 5: destination-register tag width.
- LAT, FINV_LAT+2: total in_valid → out_valid latency (derived, not overridable).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- in_valid  in  1  issue strobe; one op per cycle max
- in_a  in  32  dividend (IEEE-754 single)
- in_b  in  32  divisor (IEEE-754 single)
- in_tag  in  TAG_W  destination register of the op
- q_tag  in  TAG_W  hazard query tag
- q_hit  out  1  some in-flight op targets q_tag
- busy  out  1  any op in flight
- out_valid  out  1  result strobe, single cycle
- out_data  out  32  quotient
- out_tag  out  TAG_W  tag of out_data

Behaviour:
- Reset: synchronous, active-low. On clk edge with rstn=0:
  - all valid bits, tag regs, a-delay regs and stage regs clear to 0.
  - out_valid=0, out_data=0, out_tag=0, busy=0, q_hit=0 from the next cycle.
  - Ops in flight at reset are discarded and never emerge. finv's internal regs reset via its own rstn.
- Stages 0..FINV_LAT-1:
  - in_b drives finv `x` directly.
  - {valid, tag, a} shift through FINV_LAT registers, aligned so that in cycle FINV_LAT the delayed a matches finv `y`.
- Stage M1 (cycle FINV_LAT → FINV_LAT+1):
  - Register sign, operand exponents, special-case class and the 48-bit product of {1,ma}×{1,my}.
  - Classification priority (first match wins):
    1. a exp==0 → signed zero
    2. b exp==0 → signed inf (finv returns inf)
    3. a exp==255 → signed inf
    4. b exp==255 → signed zero
    5. otherwise normal
  - No NaN or denormal support; denormals are flushed to zero.
- Stage M2 (→ cycle LAT):
  - Sign = sa ^ sb.
  - If product[47]=1: mantissa = product[46:24], guard = product[23], exp = ea+ey-126. Otherwise: mantissa = product[45:23], guard = product[22], exp = ea+ey-127.
  - Rounding is round-half-up: mantissa += guard. A mantissa carry-out sets mantissa 0 and increments exp.
  - Exponent arithmetic is 10-bit signed. exp ≥ 255 → signed inf {s,8'hFF,0}; exp ≤ 0 → signed zero.
  - out_data, out_tag and out_valid are registered outputs.
- Throughput: one op per cycle. out_valid asserts exactly LAT cycles after in_valid, in issue order.
- Bubbles: in_valid=0 creates a bubble that propagates. The data path still clocks, but out_valid=0 for that slot.
- busy: combinational OR of all registered valid bits, stages 1..LAT, excluding the current in_valid.
- q_hit: combinational; 1 iff some registered stage 1..LAT has valid=1 and tag==q_tag. This includes the stage currently driving out_valid.
- Boundaries:
  - Simultaneous issue and retire of the same tag: q_hit reflects only registered stages.
  - Continuous issue never stalls or drops ops.

Decomposition:
- Shared FPU package holds:
  - float field widths and positions: sign 31, exp 30:23, mant 22:0
  - EXP_BIAS=127 and EXP_MAX=255
  - special-case class enum: NORMAL, ZERO, INF
  - float constants +inf, -inf, +0
- Sub-modules:
  - Instantiates the existing `finv`.
  - One new sub-module is natural: `fmul_core`, the 2-stage multiply/normalise/round back end (M1, M2) taking the class override. It is reusable as the standalone FPU multiplier.
  - The delay line and valid/tag tracking stay in fdiv_pipe.

Test Plan:
- a=0x40C00000 (6.0), b=0x40000000 (2.0), tag=3 → 5 cycles later out_valid=1, out_data=0x40400000, out_tag=3; exactly one pulse.
- a=0xBF800000 (-1.0), b=0x40800000 (4.0) → out_data=0xBE800000. Then a=0x3F800000, b=0x00000000 → 0x7F800000. Then a=0x00000000, b=0x40400000 → 0x00000000.
- Back-to-back: 4 ops on consecutive cycles with tags 1,2,3,4 plus random normal operands → out_valid high on 4 consecutive cycles 5 cycles later, tags 1..4 in order. Results within 1 ulp of a reference model; exact for power-of-two b.
- Hazard: issue tag 7 at cycle 0, hold q_tag=7 → q_hit=0 at cycle 0, q_hit=1 in cycles 1..5, q_hit=0 at cycle 6. busy follows the same pattern. q_tag=8 gives q_hit=0 throughout.
- Reset mid-flight: issue 3 ops, assert rstn=0 for 1 cycle at cycle 2 → busy=0 and q_hit=0 next cycle; no out_valid for 10 cycles afterwards. A fresh op afterwards completes normally at latency 5.
- Overflow/underflow: a=0x7F000000, b=0x3E800000 (0.25) → 0x7F800000; a=0x00800000, b=0x40800000 → 0x00000000.
